// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming KERNEL_DIM x KERNEL_DIM convolution with zero-padded borders,
// runtime double-buffered kernel and valid/ready flow control on both sides.
module conv2d_stream #(
   parameter int WORD_SIZE   = 8,
   parameter int ROW_SIZE    = 540,
   parameter int NUM_ROWS    = 540,
   parameter int KERNEL_DIM  = 3,
   parameter int COEFF_WIDTH = 8,
   parameter int SHIFT       = 0
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic [WORD_SIZE-1:0]                          in_pixel,
   input  logic                                          in_valid,
   output logic                                          in_ready,
   output logic [WORD_SIZE-1:0]                          out_pixel,
   output logic                                          out_valid,
   input  logic                                          out_ready,
   output logic                                          out_last,
   input  logic                                          mode,
   input  logic                                          coeff_we,
   input  logic [$clog2(KERNEL_DIM*KERNEL_DIM)-1:0]      coeff_addr,
   input  logic signed [COEFF_WIDTH-1:0]                 coeff_data,
   output logic                                          frame_done
);
   localparam int K  = KERNEL_DIM;
   localparam int KK = K * K;
   localparam int H  = K / 2;
   localparam int N  = ROW_SIZE * NUM_ROWS;
   localparam int D  = H * ROW_SIZE + H;
   localparam int AW = $clog2(KK);
   localparam int CW = $clog2(N + D);
   localparam int XW = ROW_SIZE > 1 ? $clog2(ROW_SIZE) : 1;
   localparam int YW = $clog2(NUM_ROWS + 1);
   localparam int PW = WORD_SIZE + 1 + COEFF_WIDTH;
   localparam int SW = PW + $clog2(KK);
   localparam logic signed [COEFF_WIDTH-1:0] CTR  = COEFF_WIDTH'(KK - 1);
   localparam logic signed [COEFF_WIDTH-1:0] NEG1 = '1;
   localparam logic signed [SW-1:0]          PMAX = SW'((1 << WORD_SIZE) - 1);

   typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;
   state_t state, state_nx;

   logic                          alive, en, adv, issue, last_adv, frame_start;
   logic [CW-1:0]                 acnt;
   logic [XW-1:0]                 colp, wx;
   logic [YW-1:0]                 wy;
   logic [WORD_SIZE-1:0]          smp, clipped;
   logic [WORD_SIZE-1:0]          line [K-1][ROW_SIZE];
   logic [WORD_SIZE-1:0]          win [K][K];
   logic [WORD_SIZE-1:0]          tap [KK];
   logic signed [COEFF_WIDTH-1:0] shadow [KK];
   logic signed [COEFF_WIDTH-1:0] active [KK];
   logic signed [PW-1:0]          prod [KK];
   logic signed [SW-1:0]          tree, sum, shf, mag;
   logic                          mode_r, v0, l0, v1, l1, m1, v2, l2, m2;

   assign en          = !out_valid || out_ready;
   assign in_ready    = alive && en && state != FLUSH;
   assign adv         = state == FLUSH ? en : in_valid && in_ready;
   assign issue       = adv && acnt >= CW'(D);
   assign last_adv    = acnt == CW'(N + D - 1);
   assign frame_start = adv && state == FILL && acnt == '0;
   assign smp         = state == FLUSH ? '0 : in_pixel;
   assign frame_done  = out_valid && out_ready && out_last;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= FILL;
      else state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (adv && state == FILL && acnt == CW'(D - 1)) state_nx = RUN;
      if (adv && state == RUN && acnt == CW'(N - 1)) state_nx = FLUSH;
      if (adv && state == FLUSH && last_adv) state_nx = FILL;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alive     <= 1'b0;
         acnt      <= '0;
         colp      <= '0;
         wx        <= '0;
         wy        <= '0;
         mode_r    <= 1'b0;
         {v0, l0, v1, l1, m1, v2, l2, m2} <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_pixel <= '0;
         for (int i = 0; i < KK; i++) begin
            shadow[i] <= i == KK / 2 ? CTR : NEG1;
            active[i] <= i == KK / 2 ? CTR : NEG1;
         end
      end else begin
         alive <= 1'b1;
         if (coeff_we && coeff_addr < AW'(KK)) shadow[coeff_addr] <= coeff_data;
         // non-blocking copy takes the shadow as it was before any same-cycle write
         if (frame_start) begin
            active <= shadow;
            mode_r <= mode;
         end
         if (adv) begin
            acnt <= last_adv ? '0 : acnt + 1'b1;
            colp <= (last_adv || colp == XW'(ROW_SIZE - 1)) ? '0 : colp + 1'b1;
         end
         if (issue) begin
            wx <= (acnt == CW'(D) || wx == XW'(ROW_SIZE - 1)) ? '0 : wx + 1'b1;
            wy <= acnt == CW'(D) ? '0 : wy + YW'(wx == XW'(ROW_SIZE - 1));
         end
         if (en) begin
            v0        <= issue;
            l0        <= issue && last_adv;
            v1        <= v0;
            l1        <= l0;
            m1        <= mode_r;
            v2        <= v1;
            l2        <= l1;
            m2        <= m1;
            out_valid <= v2;
            out_last  <= v2 && l2;
            out_pixel <= clipped;
         end
      end
   end

   // line buffers and window hold no control state, so they need no reset
   always_ff @(posedge clk) begin
      if (adv) begin
         line[0][colp] <= smp;
         for (int j = 1; j < K - 1; j++) line[j][colp] <= line[j-1][colp];
         for (int r = 0; r < K; r++)
            for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
         win[K-1][K-1] <= smp;
         for (int j = 1; j < K; j++) win[K-1-j][K-1] <= line[j-1][colp];
      end
      if (en) begin
         for (int i = 0; i < KK; i++) prod[i] <= PW'($signed({1'b0, tap[i]})) * PW'(active[i]);
         sum <= tree;
      end
   end

   always_comb begin
      tap = '{default: '0};
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++)
            tap[r*K+c] = (int'(wy) + r - H >= 0 && int'(wy) + r - H < NUM_ROWS &&
                          int'(wx) + c - H >= 0 && int'(wx) + c - H < ROW_SIZE) ? win[r][c] : '0;
   end

   always_comb begin
      tree = '0;
      for (int i = 0; i < KK; i++) tree = tree + SW'(prod[i]);
   end

   always_comb begin
      shf     = sum >>> SHIFT;
      mag     = (m2 && shf[SW-1]) ? -shf : shf;
      clipped = mag[SW-1] ? '0 : mag > PMAX ? '1 : mag[WORD_SIZE-1:0];
   end
endmodule

// File: tb/tb_conv2d_stream.sv
// tb_conv2d_stream: randomized scoreboard bench for conv2d_stream on a 4x4 frame with a 3x3 kernel,
// expected frames come from a plain zero-padded convolution of the stimulus image.
module tb_conv2d_stream;
   localparam int W = 8, R = 4, NR = 4, K = 3, KK = K * K, H = K / 2, N = R * NR, D = H * R + H;

   logic              clk = 1'b0, rst = 1'b0;
   logic [W-1:0]      in_pixel = '0, out_pixel;
   logic              in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_last, frame_done;
   logic              mode = 1'b0, coeff_we = 1'b0;
   logic [3:0]        coeff_addr = '0;
   logic signed [7:0] coeff_data = '0;

   int total = 0, bad = 0, cyc = 0, fv_cyc = -1, wr_from = -1, cnt = 0;
   int exp_q[$], wa_q[$], wd_q[$];
   int img[N], shadow_m[KK], acc_at[N];
   bit stall_mode = 1'b0, arm = 1'b0;

   conv2d_stream #(.WORD_SIZE(W), .ROW_SIZE(R), .NUM_ROWS(NR), .KERNEL_DIM(K),
                   .COEFF_WIDTH(8), .SHIFT(0)) dut (
      .clk(clk), .rst(rst), .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
      .out_pixel(out_pixel), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .mode(mode), .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
      .frame_done(frame_done));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial forever begin
      @(negedge clk);
      out_ready = stall_mode ? !out_ready : 1'b1;
   end

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic default_kernel();
      for (int i = 0; i < KK; i++) shadow_m[i] = i == KK / 2 ? KK - 1 : -1;
   endtask

   task automatic push_frame();
      int s, yy, xx;
      for (int y = 0; y < NR; y++)
         for (int x = 0; x < R; x++) begin
            s = 0;
            for (int r = 0; r < K; r++)
               for (int c = 0; c < K; c++) begin
                  yy = y + r - H;
                  xx = x + c - H;
                  if (yy >= 0 && yy < NR && xx >= 0 && xx < R) s += img[yy*R+xx] * shadow_m[r*K+c];
               end
            if (mode && s < 0) s = -s;
            s = s < 0 ? 0 : s > 255 ? 255 : s;
            exp_q.push_back(s | (y * R + x == N - 1 ? 256 : 0));
         end
   endtask

   task automatic send_pix(input int v, input int idx);
      int t, a;
      t = 0;
      in_valid = 1'b1;
      in_pixel = W'(v);
      #1;
      while (!in_ready && t < 100) begin
         @(negedge clk);
         #1;
         t++;
      end
      if (!in_ready) check("accept_timeout", 0, 1);
      acc_at[idx] = cyc + 1;
      if (wr_from >= 0 && idx >= wr_from && wa_q.size() > 0) begin
         a = wa_q.pop_front();
         shadow_m[a] = wd_q.pop_front();
         coeff_we = 1'b1;
         coeff_addr = 4'(a);
         coeff_data = 8'(shadow_m[a]);
      end
      @(negedge clk);
      in_valid = 1'b0;
      coeff_we = 1'b0;
   endtask

   task automatic send_frame(input bit gaps);
      push_frame();
      for (int i = 0; i < N; i++) begin
         if (gaps && $urandom_range(0, 2) == 0) @(negedge clk);
         send_pix(img[i], i);
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() > 0 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      check("drain_left", exp_q.size(), 0);
      @(negedge clk);
   endtask

   initial begin
      bit hold_prev;
      int e, hp;
      hold_prev = 1'b0;
      hp = 0;
      forever begin
         @(negedge clk);
         #3;
         if (!rst) hold_prev = 1'b0;
         else begin
            if (hold_prev) check("hold", {out_valid, out_last, out_pixel}, hp);
            if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
            hold_prev = out_valid && !out_ready;
            hp = {1'b1, out_last, out_pixel};
            if (arm && out_valid && fv_cyc < 0) fv_cyc = cyc;
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) check("unexpected_out", out_pixel, -1);
               else begin
                  e = exp_q.pop_front();
                  check("out{done,last,pix}", {frame_done, out_last, out_pixel},
                        (e & 255) | (e & 256) | ((e & 256) << 1));
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

   initial begin
      default_kernel();
      repeat (2) @(negedge clk);
      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_pixel", out_pixel, 0);
      check("rst_frame_done", frame_done, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("ready_before_edge", in_ready, 0);
      @(negedge clk);
      #1;
      check("ready_after_edge", in_ready, 1);
      @(negedge clk);

      // flat frame, no stalls: border pattern, latency and flush length
      for (int i = 0; i < N; i++) img[i] = 10;
      fv_cyc = -1;
      arm = 1'b1;
      send_frame(1'b0);
      cnt = 0;
      for (int t = 0; t < 50; t++) begin
         #1;
         if (in_ready) break;
         cnt++;
         @(negedge clk);
      end
      check("flush_ready_low", cnt, D);
      drain();
      arm = 1'b0;
      check("latency", fv_cyc - acc_at[D], 3);

      // impulse at (1,1) in both modes
      for (int i = 0; i < N; i++) img[i] = i == R + 1 ? 20 : 0;
      mode = 1'b0;
      send_frame(1'b0);
      drain();
      mode = 1'b1;
      send_frame(1'b0);
      drain();
      mode = 1'b0;

      // flat frame under output backpressure and input gaps
      for (int i = 0; i < N; i++) img[i] = 10;
      stall_mode = 1'b1;
      send_frame(1'b1);
      drain();
      stall_mode = 1'b0;

      // identity written mid-frame, then a write coincident with the next frame start
      for (int i = 0; i < KK; i++) begin
         wa_q.push_back(i);
         wd_q.push_back(i == KK / 2 ? 1 : 0);
      end
      wr_from = 7;
      send_frame(1'b0);
      for (int i = 0; i < N; i++) img[i] = i;
      wa_q.push_back(KK / 2);
      wd_q.push_back(2);
      wr_from = 0;
      send_frame(1'b0);
      wr_from = -1;
      send_frame(1'b0);
      drain();

      // random frames, kernels, modes, stalls and gaps
      for (int f = 0; f < 6; f++) begin
         for (int i = 0; i < N; i++) img[i] = int'($urandom_range(0, 255));
         mode = 1'($urandom_range(0, 1));
         stall_mode = 1'($urandom_range(0, 1));
         for (int w = 0; w < 3; w++) begin
            wa_q.push_back(int'($urandom_range(0, KK - 1)));
            wd_q.push_back(int'($urandom_range(0, 16)) - 8);
         end
         wr_from = int'($urandom_range(0, N - 1));
         send_frame(1'b1);
      end
      drain();
      stall_mode = 1'b0;
      wr_from = -1;
      wa_q.delete();
      wd_q.delete();
      mode = 1'b0;
      repeat (2) @(negedge clk);

      // reset in the middle of a frame, with an output already presented
      for (int i = 0; i < N; i++) img[i] = 10;
      for (int i = 0; i < 7; i++) send_pix(img[i], i);
      repeat (2) @(negedge clk);
      check("pre_reset_valid", out_valid, 1);
      rst = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_out_pixel", out_pixel, 0);
      check("mid_rst_in_ready", in_ready, 0);
      check("mid_rst_out_last", out_last, 0);
      exp_q.delete();
      default_kernel();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      send_frame(1'b0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
